sq_mem_port_arbiter: RTL and testbench

- Shares the single data-memory request port between the load path and the store queue drain.
- Loads have priority to minimise load-use latency; a saturating starvation counter and the store queue full flag force store drains.
- Also sequences fence drains: loads are held off until every queued store has left and the port is idle.
- Sits between load issue, the store queue output and the memory sub-unit.

---
 rtl/sq_mem_port_arbiter_if.sv | 20 ++
 rtl/sq_mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_sq_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sq_mem_port_arbiter_if.sv
// Single-request data-memory port between the load/store arbiter and the memory sub-unit.
// The master holds the request and payload stable until mem_ready is sampled high.
interface sq_mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_rnw;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_rnw, mem_addr, mem_be, mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req, mem_rnw, mem_addr, mem_be, mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/sq_mem_port_arbiter.sv
// Arbitrates the single data-memory port between load issue and store-queue drain.
// Loads normally win; starvation, a full store queue or a fence drain force stores through.
module sq_mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic        ld_blocked,
  input  logic [31:0] ld_addr,
  output logic        ld_ack,
  input  logic        sq_valid,
  input  logic        sq_full,
  input  logic        sq_empty,
  input  logic [31:0] sq_addr,
  input  logic [3:0]  sq_be,
  input  logic [31:0] sq_data,
  output logic        sq_pop,
  input  logic        fence_req,
  output logic        fence_done,
  sq_mem_port_arbiter_if.master mem
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          slot_free;
  logic          ld_eligible;
  logic          store_urgent;
  logic          grant_st;
  logic          grant_ld;

  assign slot_free    = ~mem.mem_req | mem.mem_ready;
  assign ld_eligible  = ld_valid & ~ld_blocked & (state == IDLE);
  assign store_urgent = sq_full | (starve_cnt == LIMIT) | (state == DRAIN);

  // Grants are combinational so the output stage can refill in the same cycle it drains.
  assign grant_st = rst & slot_free & sq_valid & (store_urgent | ~ld_eligible);
  assign grant_ld = rst & slot_free & ld_eligible & ~grant_st;

  assign sq_pop = grant_st;
  assign ld_ack = grant_ld;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the payload registers are reset too, so the port never presents X after reset.
    if (!rst) begin
      mem.mem_req   <= 1'b0;
      mem.mem_rnw   <= 1'b1;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
      fence_done    <= 1'b0;
      starve_cnt    <= '0;
      state         <= IDLE;
    end else begin
      if (grant_st) begin
        mem.mem_req   <= 1'b1;
        mem.mem_rnw   <= 1'b0;
        mem.mem_addr  <= sq_addr;
        mem.mem_be    <= sq_be;
        mem.mem_wdata <= sq_data;
      end else if (grant_ld) begin
        mem.mem_req   <= 1'b1;
        mem.mem_rnw   <= 1'b1;
        mem.mem_addr  <= ld_addr;
        mem.mem_be    <= 4'hF;
        mem.mem_wdata <= '0;
      end else if (mem.mem_ready) begin
        mem.mem_req   <= 1'b0;
      end

      if (sq_empty || grant_st) begin
        starve_cnt <= '0;
      end else if (grant_ld && sq_valid && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      fence_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fence_req) state <= DRAIN;
        end
        DRAIN: begin
          // The drain is complete only once the last store has also left the output stage.
          if (sq_empty && !mem.mem_req) begin
            state      <= DONE;
            fence_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sq_mem_port_arbiter.sv
// Directed bench for sq_mem_port_arbiter: stimulus pushes expected memory transactions,
// a monitor pops and compares each one as the memory port accepts it.
module tb_sq_mem_port_arbiter;

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_blocked;
  logic [31:0] ld_addr;
  logic        ld_ack;
  logic        sq_valid;
  logic        sq_full;
  logic        sq_empty;
  logic [31:0] sq_addr;
  logic [3:0]  sq_be;
  logic [31:0] sq_data;
  logic        sq_pop;
  logic        fence_req;
  logic        fence_done;

  int n_checks = 0;
  int n_fail   = 0;
  txn_t sb[$];

  sq_mem_port_arbiter_if m ();

  sq_mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_blocked (ld_blocked),
    .ld_addr    (ld_addr),
    .ld_ack     (ld_ack),
    .sq_valid   (sq_valid),
    .sq_full    (sq_full),
    .sq_empty   (sq_empty),
    .sq_addr    (sq_addr),
    .sq_be      (sq_be),
    .sq_data    (sq_data),
    .sq_pop     (sq_pop),
    .fence_req  (fence_req),
    .fence_done (fence_done),
    .mem        (m.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle: check the grant outputs mid-cycle, record the expected
  // transaction, then return just after the next rising edge ready for new inputs.
  task automatic cyc(input logic exp_ld, input logic exp_sq, input logic exp_fd);
    txn_t t;
    @(negedge clk);
    check("ld_ack", 32'(ld_ack), 32'(exp_ld));
    check("sq_pop", 32'(sq_pop), 32'(exp_sq));
    check("fence_done", 32'(fence_done), 32'(exp_fd));
    if (exp_sq) begin
      t = '{rnw: 1'b0, addr: sq_addr, be: sq_be, wdata: sq_data};
      sb.push_back(t);
    end else if (exp_ld) begin
      t = '{rnw: 1'b1, addr: ld_addr, be: 4'hF, wdata: 32'h0};
      sb.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted request must match the oldest expected transaction.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst && m.mem_req && m.mem_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got addr %h with no transaction expected", m.mem_addr);
        end else begin
          e = sb.pop_front();
          check("sb_rnw",   32'(m.mem_rnw), 32'(e.rnw));
          check("sb_addr",  m.mem_addr,     e.addr);
          check("sb_be",    32'(m.mem_be),  32'(e.be));
          check("sb_wdata", m.mem_wdata,    e.wdata);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; ld_valid = 1'b1; ld_blocked = 1'b0; ld_addr = 32'h0000_0100;
    sq_valid = 1'b0; sq_full = 1'b0; sq_empty = 1'b1; sq_addr = '0; sq_be = '0; sq_data = '0;
    fence_req = 1'b0; m.mem_ready = 1'b1;

    // Reset with a load waiting: nothing is granted or issued.
    @(negedge clk);
    check("rst_ld_ack",  32'(ld_ack),     32'd0);
    check("rst_sq_pop",  32'(sq_pop),     32'd0);
    check("rst_mem_req", 32'(m.mem_req),  32'd0);
    check("rst_mem_rnw", 32'(m.mem_rnw),  32'd1);
    check("rst_addr",    m.mem_addr,      32'h0);
    check("rst_fence",   32'(fence_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    ld_valid = 1'b0;
    @(negedge clk);
    check("first_mem_req", 32'(m.mem_req), 32'd1);
    check("first_mem_rnw", 32'(m.mem_rnw), 32'd1);
    check("first_mem_be",  32'(m.mem_be),  32'hF);
    @(posedge clk); #1;

    // Starvation with STARVE_LIMIT=3: L,L,L,S,L,L,L,S.
    sq_empty = 1'b0; ld_valid = 1'b1; sq_valid = 1'b1; sq_be = 4'hF;
    for (int i = 0; i < 8; i++) begin
      logic st;
      st = (i % 4) == 3;
      ld_addr = 32'h0000_1000 + i;
      sq_addr = 32'h0000_2000 + i;
      sq_data = 32'hA000_0000 + i;
      cyc(~st, st, 1'b0);
      if (st) check("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
    end
    ld_valid = 1'b0; sq_valid = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Back-pressure: a held store stays stable for 4 stalled cycles.
    sq_valid = 1'b1; sq_addr = 32'h3000_0040; sq_data = 32'hDEAD_BEEF; sq_be = 4'h3;
    cyc(1'b0, 1'b1, 1'b0);
    m.mem_ready = 1'b0; ld_valid = 1'b1;
    sq_addr = 32'h3000_0044; sq_data = 32'h1234_5678; sq_be = 4'hC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_req",    32'(m.mem_req), 32'd1);
      check("stall_addr",   m.mem_addr,     32'h3000_0040);
      check("stall_wdata",  m.mem_wdata,    32'hDEAD_BEEF);
      check("stall_be",     32'(m.mem_be),  32'h3);
      check("stall_ld_ack", 32'(ld_ack),    32'd0);
      check("stall_sq_pop", 32'(sq_pop),    32'd0);
      @(posedge clk); #1;
    end
    m.mem_ready = 1'b1; ld_valid = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    sq_valid = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // A full store queue beats a pending load even with no starvation.
    check("full_starve_zero", 32'(dut.starve_cnt), 32'd0);
    ld_valid = 1'b1; ld_addr = 32'h4000_0000;
    sq_valid = 1'b1; sq_full = 1'b1; sq_addr = 32'h5000_0000; sq_data = 32'h0F0F_0F0F; sq_be = 4'hF;
    cyc(1'b0, 1'b1, 1'b0);
    sq_full = 1'b0; sq_valid = 1'b0; ld_valid = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Fence: load in the fence cycle issues, then two stores drain, then one done pulse.
    ld_valid = 1'b1; ld_addr = 32'h7000_0000;
    sq_valid = 1'b1; sq_addr = 32'h6000_0000; sq_data = 32'h1111_1111; fence_req = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    fence_req = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    sq_addr = 32'h6000_0004; sq_data = 32'h2222_2222; fence_req = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    fence_req = 1'b0; sq_valid = 1'b0; sq_empty = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    ld_addr = 32'h7000_0010;
    cyc(1'b1, 1'b0, 1'b0);
    ld_valid = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Blocked load: store goes first, nothing while blocked alone, load once unblocked.
    sq_empty = 1'b0; ld_valid = 1'b1; ld_blocked = 1'b1; ld_addr = 32'h8000_0000;
    sq_valid = 1'b1; sq_addr = 32'h9000_0000; sq_data = 32'h5555_AAAA; sq_be = 4'h1;
    cyc(1'b0, 1'b1, 1'b0);
    sq_valid = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    ld_blocked = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    ld_valid = 1'b0; sq_empty = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
